// File: rtl/mmio_coproc_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mmio_coproc_responder_pkg
// Purpose  : Shared types and constants for the coprocessor MMIO responder.
//            - coprocessor FSM state encoding
//            - register offsets inside the 256-byte window
//            - STATUS and CTRL bit positions
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mmio_coproc_responder_pkg;

  // Coprocessor control FSM state, 2-bit explicit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } coproc_state_t;

  // Register offsets (IO_ADDR[7:0]); only these exact word-aligned values decode.
  localparam logic [7:0] CP_CTRL   = 8'h00;
  localparam logic [7:0] CP_CMD    = 8'h04;
  localparam logic [7:0] CP_SRC    = 8'h08;
  localparam logic [7:0] CP_DST    = 8'h0C;
  localparam logic [7:0] CP_LEN    = 8'h10;
  localparam logic [7:0] CP_CYCLES = 8'h14;

  // STATUS read bits. ST_DONE must stay at bit 1: the CPU's LWCP stall
  // polls exactly that bit.
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int ST_W    = 3;

  // CTRL write bits.
  localparam int CTRL_START = 0;
  localparam int CTRL_CLR   = 1;

  // Assemble the 3-bit status field from the individual flags so the bit
  // placement is defined in exactly one place.
  function automatic logic [ST_W-1:0] pack_status(input logic busy,
                                                  input logic done,
                                                  input logic err);
    logic [ST_W-1:0] s;
    s          = '0;
    s[ST_BUSY] = busy;
    s[ST_DONE] = done;
    s[ST_ERR]  = err;
    return s;
  endfunction

endpackage : mmio_coproc_responder_pkg
`default_nettype wire

// File: rtl/mmio_coproc_responder_decode.sv
`default_nettype none
// ============================================================================
// Module   : mmio_reg_decode
// Purpose  : Combinational front end of the coprocessor MMIO responder:
//            window hit, offset decode into per-register write strobes, and
//            the zero-wait-state read mux.
// Ports    :
//   IO_ADDR   in  BITS  byte address from the CPU
//   IO_WEN    in  1     write enable (already IO-range qualified)
//   IO_RDEN   in  1     read enable (already IO-range qualified)
//   status    in  3     packed {ERR, DONE, BUSY}
//   cmd       in  8     CMD register
//   src       in  BITS  SRC register
//   dst       in  BITS  DST register
//   len       in  BITS  LEN register
//   cycles    in  CNTW  RUN cycle count of the last run
//   IO_RDATA  out BITS  read data, zero unless a read hits the window
//   wr_ctrl   out 1     write strobe for CTRL
//   wr_cmd    out 1     write strobe for CMD
//   wr_src    out 1     write strobe for SRC
//   wr_dst    out 1     write strobe for DST
//   wr_len    out 1     write strobe for LEN
// Revision : 1.0 - initial release
// ============================================================================
module mmio_reg_decode
  import mmio_coproc_responder_pkg::*;
#(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] BASE_ADDR = 32'h0001_0000,
  parameter int              CNTW      = 24
) (
  input  logic [BITS-1:0] IO_ADDR,
  input  logic            IO_WEN,
  input  logic            IO_RDEN,
  input  logic [ST_W-1:0] status,
  input  logic [7:0]      cmd,
  input  logic [BITS-1:0] src,
  input  logic [BITS-1:0] dst,
  input  logic [BITS-1:0] len,
  input  logic [CNTW-1:0] cycles,
  output logic [BITS-1:0] IO_RDATA,
  output logic            wr_ctrl,
  output logic            wr_cmd,
  output logic            wr_src,
  output logic            wr_dst,
  output logic            wr_len
);

  logic       hit;
  logic [7:0] offset;
  logic       wr_sel;

  // The window is 256 bytes, so everything above bit 7 selects the block.
  assign hit    = (IO_ADDR[BITS-1:8] == BASE_ADDR[BITS-1:8]);
  assign offset = IO_ADDR[7:0];
  assign wr_sel = IO_WEN & hit;

  // Exact offset compares: a misaligned address never matches a register,
  // so it reads zero and its writes vanish. CYCLES has no strobe (read-only).
  assign wr_ctrl = wr_sel & (offset == CP_CTRL);
  assign wr_cmd  = wr_sel & (offset == CP_CMD);
  assign wr_src  = wr_sel & (offset == CP_SRC);
  assign wr_dst  = wr_sel & (offset == CP_DST);
  assign wr_len  = wr_sel & (offset == CP_LEN);

  // Read mux; zero when not selected so the CPU can OR several responders.
  always_comb begin
    IO_RDATA = '0;
    if (IO_RDEN && hit) begin
      case (offset)
        CP_CTRL:   IO_RDATA = BITS'(status);
        CP_CMD:    IO_RDATA = BITS'(cmd);
        CP_SRC:    IO_RDATA = src;
        CP_DST:    IO_RDATA = dst;
        CP_LEN:    IO_RDATA = len;
        CP_CYCLES: IO_RDATA = BITS'(cycles);
        default:   IO_RDATA = '0;
      endcase
    end
  end

endmodule : mmio_reg_decode
`default_nettype wire

// File: rtl/mmio_coproc_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_coproc_responder
// Purpose  : MMIO register block fronting the image coprocessor. Holds the
//            command/config registers, launches runs with a one-cycle start
//            pulse, times runs out, and reports BUSY/DONE/ERR combinationally
//            so the CPU's LWCP stall releases in the first DONE cycle.
// Ports    :
//   clk       in  1     global clock
//   rst_n     in  1     asynchronous active-low reset (shared with coprocessor)
//   IO_ADDR   in  BITS  byte address from the CPU MEM stage
//   IO_WDATA  in  BITS  write data
//   IO_WEN    in  1     write enable
//   IO_RDEN   in  1     read enable
//   IO_RDATA  out BITS  combinational read data
//   cp_start  out 1     one-cycle start pulse (first RUN cycle)
//   cp_cmd    out 8     opcode register
//   cp_src    out BITS  source address register
//   cp_dst    out BITS  destination address register
//   cp_len    out BITS  transfer length register
//   cp_done   in  1     one-cycle completion pulse
//   irq       out 1     high while STATUS.DONE = 1
// Revision : 1.0 - initial release
// ============================================================================
module mmio_coproc_responder
  import mmio_coproc_responder_pkg::*;
#(
  parameter int              BITS      = 32,
  parameter logic [BITS-1:0] BASE_ADDR = 32'h0001_0000,
  parameter int              TIMEOUT   = 1_000_000,
  parameter int              CNTW      = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [BITS-1:0] IO_ADDR,
  input  logic [BITS-1:0] IO_WDATA,
  input  logic            IO_WEN,
  input  logic            IO_RDEN,
  output logic [BITS-1:0] IO_RDATA,
  output logic            cp_start,
  output logic [7:0]      cp_cmd,
  output logic [BITS-1:0] cp_src,
  output logic [BITS-1:0] cp_dst,
  output logic [BITS-1:0] cp_len,
  input  logic            cp_done,
  output logic            irq
);

  // Timeout counter only has to reach TIMEOUT-1.
  localparam int            TW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CYC_MAX = '1;

  coproc_state_t   state;
  coproc_state_t   state_nxt;

  logic            err;
  logic            start_q;
  logic [7:0]      cmd_q;
  logic [BITS-1:0] src_q;
  logic [BITS-1:0] dst_q;
  logic [BITS-1:0] len_q;
  logic [CNTW-1:0] cycles_q;
  logic [TW-1:0]   tcnt_q;

  logic            wr_ctrl;
  logic            wr_cmd;
  logic            wr_src;
  logic            wr_dst;
  logic            wr_len;
  logic            start_bit;
  logic            clr_bit;

  logic            busy;
  logic            done_st;
  logic            cfg_ok;
  logic            start_fire;
  logic            clr_fire;
  logic            timeout_hit;
  logic            run_violation;
  logic [ST_W-1:0] status;

  assign start_bit = IO_WDATA[CTRL_START];
  assign clr_bit   = IO_WDATA[CTRL_CLR];

  // --------------------------------------------------------------------------
  // Address decode and read mux
  // --------------------------------------------------------------------------
  mmio_reg_decode #(
    .BITS      (BITS),
    .BASE_ADDR (BASE_ADDR),
    .CNTW      (CNTW)
  ) u_decode (
    .IO_ADDR  (IO_ADDR),
    .IO_WEN   (IO_WEN),
    .IO_RDEN  (IO_RDEN),
    .status   (status),
    .cmd      (cmd_q),
    .src      (src_q),
    .dst      (dst_q),
    .len      (len_q),
    .cycles   (cycles_q),
    .IO_RDATA (IO_RDATA),
    .wr_ctrl  (wr_ctrl),
    .wr_cmd   (wr_cmd),
    .wr_src   (wr_src),
    .wr_dst   (wr_dst),
    .wr_len   (wr_len)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (wr_ctrl && start_bit) state_nxt = RUN;
      end
      RUN: begin
        // Completion and timeout both land in DONE; they differ only in ERR.
        if (cp_done || timeout_hit) state_nxt = DONE;
      end
      DONE: begin
        // CLR has priority over START when both are written together.
        if (wr_ctrl && clr_bit)        state_nxt = IDLE;
        else if (wr_ctrl && start_bit) state_nxt = RUN;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: state-derived controls
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    done_st    = 1'b0;
    cfg_ok     = 1'b0;
    start_fire = 1'b0;
    clr_fire   = 1'b0;
    case (state)
      IDLE: begin
        cfg_ok     = 1'b1;
        start_fire = wr_ctrl & start_bit;
      end
      RUN: begin
        busy = 1'b1;
      end
      DONE: begin
        done_st    = 1'b1;
        cfg_ok     = 1'b1;
        clr_fire   = wr_ctrl & clr_bit;
        start_fire = wr_ctrl & start_bit & ~clr_bit;
      end
      default: ;
    endcase
  end

  assign timeout_hit   = busy & (tcnt_q == T_LAST);
  // Touching the config or re-starting mid-run is a software bug; the write
  // is dropped and flagged rather than corrupting an in-flight transfer.
  assign run_violation = busy & (wr_cmd | wr_src | wr_dst | wr_len |
                                 (wr_ctrl & start_bit));
  assign status        = pack_status(busy, done_st, err);
  assign irq           = done_st;

  // --------------------------------------------------------------------------
  // Sticky error flag. A timeout coinciding with cp_done is a completion and
  // leaves ERR as it was; a restart from DONE keeps ERR, only CLR clears it.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (clr_fire) begin
      err <= 1'b0;
    end else if (run_violation || (timeout_hit && !cp_done)) begin
      err <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Start pulse: registered so it coincides with the first RUN cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_fire;
    end
  end

  assign cp_start = start_q;

  // --------------------------------------------------------------------------
  // Configuration registers (writable outside RUN only)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q <= '0;
      src_q <= '0;
      dst_q <= '0;
      len_q <= '0;
    end else if (cfg_ok) begin
      if (wr_cmd) cmd_q <= IO_WDATA[7:0];
      if (wr_src) src_q <= IO_WDATA;
      if (wr_dst) dst_q <= IO_WDATA;
      if (wr_len) len_q <= IO_WDATA;
    end
  end

  assign cp_cmd = cmd_q;
  assign cp_src = src_q;
  assign cp_dst = dst_q;
  assign cp_len = len_q;

  // --------------------------------------------------------------------------
  // Run counters. CYCLES is cleared on every launch and saturates; the
  // timeout counter is private and never needs to wrap because the run ends
  // when it reaches T_LAST.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycles_q <= '0;
      tcnt_q   <= '0;
    end else if (start_fire) begin
      cycles_q <= '0;
      tcnt_q   <= '0;
    end else if (busy) begin
      if (cycles_q != CYC_MAX) cycles_q <= cycles_q + CNTW'(1);
      tcnt_q <= tcnt_q + TW'(1);
    end
  end

endmodule : mmio_coproc_responder
`default_nettype wire

// File: doc/mmio_coproc_responder.md
Name: mmio_coproc_responder

Overview:
Memory-mapped I/O responder on the CPU's IO bus (IO_ADDR/IO_WDATA/IO_WEN/IO_RDEN/IO_RDATA), fronting the image coprocessor.
- Holds command and configuration registers, issues a start pulse to the coprocessor, and tracks busy/done/error state.
- Returns status combinationally in the same cycle as the read, so the CPU's LWCP stall (STATUS bit 1 = DONE) resolves without an extra cycle.

Parameters:
BITS, 32, data/address width
BASE_ADDR, 32'h0001_0000, base of the 256-byte register window (selected when IO_ADDR[BITS-1:8] == BASE_ADDR[BITS-1:8])
TIMEOUT, 1_000_000, maximum RUN cycles before the run is aborted with error
CNTW, 24, width of the cycle counter

Ports:
clk  in  1  global clock
rst_n  in  1  asynchronous active-low reset
IO_ADDR  in  BITS  byte address from the CPU MEM stage
IO_WDATA  in  BITS  write data
IO_WEN  in  1  write enable, qualified by the CPU's IO range
IO_RDEN  in  1  read enable, qualified by the CPU's IO range
IO_RDATA  out  BITS  read data, combinational
cp_start  out  1  one-cycle start pulse to the coprocessor
cp_cmd  out  8  opcode register
cp_src  out  BITS  source address register
cp_dst  out  BITS  destination address register
cp_len  out  BITS  transfer length register
cp_done  in  1  one-cycle completion pulse from the coprocessor
irq  out  1  level signal, high while STATUS.DONE = 1

Behaviour:
Register map (offset = IO_ADDR[7:0]; only word-aligned offsets decode):
- 0x00 CTRL/STATUS
  - Write: bit0 START, bit1 CLR.
  - Read: {29'b0, ERR[2], DONE[1], BUSY[0]}.
- 0x04 CMD: RW, bits [7:0]; upper bits read 0.
- 0x08 SRC: RW.
- 0x0C DST: RW.
- 0x10 LEN: RW.
- 0x14 CYCLES: RO, zero-extended count of RUN cycles from the last run.
- Any other offset reads 0; writes to it are ignored.

Read path:
- IO_RDATA = selected register when (IO_RDEN & window hit); otherwise 0.
- Purely combinational; zero wait states.

Reset:
- State IDLE.
- CMD/SRC/DST/LEN/CYCLES = 0.
- ERR = 0; cp_start = 0; irq = 0.
- Reset mid-RUN aborts immediately. The coprocessor shares rst_n.

FSM (state_t: IDLE, RUN, DONE). BUSY = (state==RUN); DONE = (state==DONE).
- IDLE
  - Write CTRL with START=1 → RUN.
  - cp_start = 1 in the following cycle only. The pulse is registered, so it is asserted the first cycle state==RUN.
  - CYCLES cleared to 0; timeout counter cleared.
- RUN
  - CYCLES increments each cycle, saturating at 2^CNTW−1.
  - cp_done = 1 → DONE next edge. STATUS.DONE reads 1 from that edge onward.
  - Timeout counter reaches TIMEOUT−1 without cp_done → DONE with ERR = 1.
  - cp_done and timeout in the same cycle → DONE, ERR unchanged (completion wins).
  - A write to CMD/SRC/DST/LEN, or START=1, while in RUN: write ignored, ERR set (sticky).
- DONE
  - Write CTRL with CLR=1 → IDLE, ERR cleared.
  - Write CTRL with START=1 (CLR=0) → RUN (restart). ERR is kept; CYCLES and timeout counter are cleared.
  - START and CLR both set → CLR wins, go to IDLE.
  - Config registers are writable in DONE.
- cp_done while IDLE or DONE is ignored.

LWCP interaction:
- While RUN, a status read returns bit1 = 0. The CPU holds IO_ADDR and IO_RDEN steady and stalls.
- The first cycle in DONE returns bit1 = 1 and releases the stall.
- Latency from cp_done to a visible DONE bit: 1 cycle.

Writes:
- Take effect at the clock edge when IO_WEN & window hit.
- Full-word writes only; the block has no byte enables.

Decomposition:
- Add to common_params:
  - coproc_state_t {IDLE, RUN, DONE}
  - register offset localparams CP_CTRL, CP_CMD, CP_SRC, CP_DST, CP_LEN, CP_CYCLES
  - status bit indices ST_BUSY = 0, ST_DONE = 1, ST_ERR = 2 (the ST_DONE index must match the LWCP stall bit)
- Optional sub-module mmio_reg_decode: combinational window hit, offset decode, and read mux. The FSM and counters stay in the top.

Test Plan:
- Reset, then read all offsets 0x00–0x18 → every read returns 0; cp_start = 0; irq = 0.
- Write SRC = 0x100, DST = 0x200, LEN = 64, CMD = 0x3, then CTRL = 0x1 → cp_start high exactly 1 cycle, cp_src = 0x100, STATUS = 0x1; read back all four registers with identical values.
- Start, assert cp_done after 10 RUN cycles → STATUS = 0x2 on the following cycle, CYCLES = 10, irq = 1; CTRL = 0x2 → STATUS = 0, irq = 0.
- Hold a status read (IO_RDEN = 1, IO_ADDR = BASE) during RUN → IO_RDATA[1] = 0 every cycle until cp_done; IO_RDATA[1] = 1 one cycle after cp_done.
- With TIMEOUT = 16, start and never pulse cp_done → STATUS = 0x6 after 16 cycles; repeat with cp_done on cycle 16 → STATUS = 0x2.
- Write LEN = 5 during RUN → LEN still holds its old value, ERR = 1. Assert rst_n = 0 mid-RUN → all outputs 0 asynchronously; state IDLE after reset release.
